// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook timer.
// Holds the controller state encodings and the BCD digit width/limit used by
// the timer core and its testbench-facing ports.
package microwave_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Controller states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_RUNNING = 3'd2;
  localparam logic [2:0] ST_PAUSED  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator.
// Counts 0..TICKS_PER_SEC-1 while enabled; tick is high for the single cycle in
// which the counter sits at its last value, so the consumer acts on the wrap edge.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clr   in  synchronous counter clear (wins over en)
//   en    in  count enable
//   tick  out 1-cycle pulse on the counter wrap
module tick_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is derived from state only (not from clr) so the consumer may compute
  // clr from its own next-state without forming a combinational loop.
  assign tick = en && (cnt_q == CNT_MAX);

  // Next counter value: clear, wrap, increment or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// Microwave cook-time entry and countdown core.
// Keypad digits shift in as MM:SS BCD, start counts down once per second,
// door/stop pause, and reaching 00:00 raises a one-cycle done pulse followed by
// a BEEP_SECONDS beep window before returning to IDLE.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   key_digit/key_valid             keypad BCD digit and its strobe
//   start, stop, clear              1-cycle command strobes
//   door_open                       door level (1 = open)
//   min_tens..sec_ones              registered BCD display digits
//   running, paused, done, beep     registered status outputs
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned BEEP_SECONDS  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BCD_W-1:0] key_digit,
  input  logic             key_valid,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             door_open,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic             beep
);

  localparam int unsigned DIG_W  = 4 * BCD_W;
  localparam int unsigned BEEP_W = (BEEP_SECONDS > 1) ? $clog2(BEEP_SECONDS + 1) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECONDS - 1);

  logic [2:0]        state_q, state_d;
  logic [DIG_W-1:0]  digits_q, digits_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              done_d;
  logic              running_q, paused_q, done_q, beep_q;
  logic              tick_s, pre_en_s, pre_clr_s;
  logic [DIG_W-1:0]  dec_s;

  // One-second decrement of MM:SS. The seconds field may hold 60..99, so a
  // borrow out of the seconds reloads 59 and never normalises the value.
  function automatic logic [DIG_W-1:0] bcd_dec(input logic [DIG_W-1:0] t);
    logic [BCD_W-1:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = BCD_MAX;
    end else if (mo != 4'd0) begin
      mo = mo - 4'd1;
      st = 4'd5;
      so = BCD_MAX;
    end else if (mt != 4'd0) begin
      mt = mt - 4'd1;
      mo = BCD_MAX;
      st = 4'd5;
      so = BCD_MAX;
    end else begin
      so = 4'd0;
    end
    return {mt, mo, st, so};
  endfunction

  assign dec_s = bcd_dec(digits_q);

  // Prescaler runs in RUNNING (countdown) and DONE (beep seconds); it is held
  // at zero elsewhere and restarted on every entry into RUNNING so the first
  // decrement lands exactly one second after start.
  assign pre_en_s  = (state_q == ST_RUNNING) || (state_q == ST_DONE);
  assign pre_clr_s = !((state_d == ST_RUNNING) || (state_d == ST_DONE)) ||
                     ((state_q != ST_RUNNING) && (state_d == ST_RUNNING));

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (pre_clr_s),
    .en   (pre_en_s),
    .tick (tick_s)
  );

  // Next-state, digit and beep-counter logic; clear beats every other input
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    beep_cnt_d = beep_cnt_q;
    done_d     = 1'b0;
    if (clear) begin
      state_d    = ST_IDLE;
      digits_d   = '0;
      beep_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SETUP: begin
          if (stop) begin
            state_d = state_q;
          end else if (start) begin
            if ((state_q == ST_SETUP) && !door_open && (digits_q != '0)) begin
              state_d = ST_RUNNING;
            end else begin
              state_d = state_q;
            end
          end else if (key_valid && (key_digit <= BCD_MAX)) begin
            digits_d = {digits_q[DIG_W-BCD_W-1:0], key_digit};
            state_d  = ST_SETUP;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUNNING: begin
          // A tick on the same cycle as a pause request is dropped
          if (door_open || stop) begin
            state_d = ST_PAUSED;
          end else if (tick_s) begin
            digits_d = dec_s;
            if (dec_s == '0) begin
              state_d    = ST_DONE;
              done_d     = 1'b1;
              beep_cnt_d = '0;
            end else begin
              state_d = ST_RUNNING;
            end
          end else begin
            state_d = ST_RUNNING;
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            state_d  = ST_IDLE;
            digits_d = '0;
          end else if (start && !door_open) begin
            state_d = ST_RUNNING;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        ST_DONE: begin
          if (stop) begin
            state_d    = ST_IDLE;
            digits_d   = '0;
            beep_cnt_d = '0;
          end else if (tick_s) begin
            if (beep_cnt_q == BEEP_LAST) begin
              state_d    = ST_IDLE;
              digits_d   = '0;
              beep_cnt_d = '0;
            end else begin
              beep_cnt_d = beep_cnt_q + BEEP_W'(1);
            end
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          digits_d   = '0;
          beep_cnt_d = '0;
        end
      endcase
    end
  end

  // State, digit and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      digits_q   <= '0;
      beep_cnt_q <= '0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      beep_cnt_q <= beep_cnt_d;
      running_q  <= (state_d == ST_RUNNING);
      paused_q   <= (state_d == ST_PAUSED);
      done_q     <= done_d;
      beep_q     <= (state_d == ST_DONE);
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = digits_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign done    = done_q;
  assign beep    = beep_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer (TICKS_PER_SEC=4, BEEP_SECONDS=2).
// Every cycle is compared against a seconds-and-minutes reference model; a
// table of directed vectors and hand-written sequences add fixed expectations.
module tb_microwave_timer;

  localparam int TPS  = 4;
  localparam int BEEP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_digit = 4'd0;
  logic       key_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, paused, done, beep;

  always #5 clk = ~clk;

  microwave_timer #(.TICKS_PER_SEC(TPS), .BEEP_SECONDS(BEEP)) dut (
    .clk(clk), .reset(reset), .key_digit(key_digit), .key_valid(key_valid),
    .start(start), .stop(stop), .clear(clear), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .paused(paused), .done(done), .beep(beep)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cook time as plain integers
  typedef enum {M_IDLE, M_SETUP, M_RUN, M_PAUSE, M_DONE} mode_e;
  mode_e m_mode = M_IDLE;
  int    m_min = 0, m_sec = 0, m_cyc = 0, m_beeps = 0;
  logic  m_done = 1'b0;

  typedef struct {
    logic rst, clr, door, stp, sta, kv;
    logic [3:0] kd;
    logic [15:0] exp_d;
    logic [3:0]  exp_f;   // {running, paused, done, beep}
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(input logic rst, clr, door, stp, sta, kv,
                              input logic [3:0] kd, input logic [15:0] ed, input logic [3:0] ef);
    vec_t v;
    v.rst = rst; v.clr = clr; v.door = door; v.stp = stp; v.sta = sta; v.kv = kv;
    v.kd = kd; v.exp_d = ed; v.exp_f = ef;
    return v;
  endfunction

  function automatic logic [19:0] dut_out();
    return {min_tens, min_ones, sec_tens, sec_ones, running, paused, done, beep};
  endfunction

  function automatic logic [19:0] model_out();
    logic [3:0] a, b, c, d;
    a = 4'(m_min / 10); b = 4'(m_min % 10);
    c = 4'(m_sec / 10); d = 4'(m_sec % 10);
    return {a, b, c, d, (m_mode == M_RUN), (m_mode == M_PAUSE), m_done, (m_mode == M_DONE)};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_mode = M_IDLE; m_min = 0; m_sec = 0; m_cyc = 0; m_beeps = 0;
  endtask

  task automatic model_step(input logic rst, clr, door, stp, sta, kv, input logic [3:0] kd);
    int val;
    m_done = 1'b0;
    if (rst || clr) begin
      model_zero();
    end else begin
      case (m_mode)
        M_IDLE, M_SETUP: begin
          if (stp) begin
          end else if (sta) begin
            if (m_mode == M_SETUP && !door && (m_min + m_sec) != 0) begin
              m_mode = M_RUN; m_cyc = 0;
            end
          end else if (kv && kd <= 4'd9) begin
            val = ((m_min * 100 + m_sec) % 1000) * 10 + int'(kd);
            m_min = val / 100; m_sec = val % 100; m_mode = M_SETUP;
          end
        end
        M_RUN: begin
          if (door || stp) begin
            m_mode = M_PAUSE; m_cyc = 0;
          end else begin
            m_cyc++;
            if (m_cyc == TPS) begin
              m_cyc = 0;
              if (m_sec > 0) m_sec--;
              else if (m_min > 0) begin m_min--; m_sec = 59; end
              if (m_min == 0 && m_sec == 0) begin
                m_mode = M_DONE; m_done = 1'b1; m_beeps = BEEP;
              end
            end
          end
        end
        M_PAUSE: begin
          if (stp) model_zero();
          else if (sta && !door) begin m_mode = M_RUN; m_cyc = 0; end
        end
        M_DONE: begin
          if (stp) model_zero();
          else begin
            m_cyc++;
            if (m_cyc == TPS) begin
              m_cyc = 0; m_beeps--;
              if (m_beeps == 0) model_zero();
            end
          end
        end
        default: model_zero();
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock, then compare DUT with the model
  task automatic cyc(input logic rst, clr, door, stp, sta, kv, input logic [3:0] kd);
    reset = rst; clear = clr; door_open = door; stop = stp; start = sta;
    key_valid = kv; key_digit = kd;
    @(posedge clk);
    #1;
    model_step(rst, clr, door, stp, sta, kv, kd);
    check("model", dut_out(), model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask
  task automatic key(input logic [3:0] d);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask
  task automatic press_start();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask
  task automatic do_clear();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  logic seen;
  int   beeps;
  logic door_lvl;

  initial begin
    //              rst   clr   door  stp   sta   kv    kd     digits    flags
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 4'b0000);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 16'h0000, 4'b0000);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 4'b0000);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0001, 4'b0000);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h0012, 4'b0000);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0123, 4'b0000);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 16'h1234, 4'b0000);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'h2345, 4'b0000);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'h2345, 4'b0000);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h2345, 4'b1000);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h2345, 4'b0100);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 16'h2345, 4'b0100);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'b0000);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 4'b0000);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 4'b0000);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 4'b0000);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].clr, tbl[i].door, tbl[i].stp, tbl[i].sta, tbl[i].kv, tbl[i].kd);
      check($sformatf("row%0d", i), dut_out(), {tbl[i].exp_d, tbl[i].exp_f});
    end

    // Scenario 1: 01:05 countdown, done pulse, beep window
    key(4'd1); key(4'd0); key(4'd5);
    press_start();
    check("t1_start", dut_out(), {16'h0105, 4'b1000});
    idle(3);
    check("t1_hold", dut_out(), {16'h0105, 4'b1000});
    idle(1);
    check("t1_first_tick", dut_out(), {16'h0104, 4'b1000});
    idle(20);
    check("t1_0059", dut_out(), {16'h0059, 4'b1000});
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      idle(1);
      if (done) begin
        seen = 1'b1;
        check("t1_done_state", dut_out(), {16'h0000, 4'b0011});
      end
    end
    check("t1_done_seen", {19'd0, seen}, 20'd1);
    beeps = 1;
    for (int i = 0; i < 20 && beep; i++) begin
      idle(1);
      if (beep) beeps++;
    end
    check("t1_beep_len", 20'(beeps), 20'd8);
    check("t1_idle_after", dut_out(), 20'h00000);

    // Scenario 2: 00:99 literal seconds and the 90 -> 89 borrow
    do_clear();
    key(4'd9); key(4'd9);
    press_start();
    check("t2_start", dut_out(), {16'h0099, 4'b1000});
    idle(4);
    check("t2_0098", dut_out(), {16'h0098, 4'b1000});
    idle(32);
    check("t2_0090", dut_out(), {16'h0090, 4'b1000});
    idle(4);
    check("t2_0089", dut_out(), {16'h0089, 4'b1000});

    // Scenario 4: door opens on the tick cycle, resume restarts the second
    do_clear();
    key(4'd1); key(4'd0);
    press_start();
    idle(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t4_paused", dut_out(), {16'h0010, 4'b0100});
    idle(1);
    press_start();
    check("t4_resume", dut_out(), {16'h0010, 4'b1000});
    idle(3);
    check("t4_hold", dut_out(), {16'h0010, 4'b1000});
    idle(1);
    check("t4_0009", dut_out(), {16'h0009, 4'b1000});

    // Scenario 6: reset mid-countdown, then clear+start together
    do_clear();
    key(4'd3);
    press_start();
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("t6_reset", dut_out(), 20'h00000);
    key(4'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check("t6_clear_start", dut_out(), 20'h00000);

    // Randomized traffic against the model
    door_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_clr, r_stp, r_sta, r_kv;
      logic [3:0] r_kd;
      r_rst = ($urandom_range(0, 299) == 0);
      r_clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 19) == 0) door_lvl = ~door_lvl;
      r_stp = ($urandom_range(0, 29) == 0);
      r_sta = ($urandom_range(0, 5) == 0);
      r_kv  = ($urandom_range(0, 2) == 0);
      r_kd  = 4'($urandom_range(0, 15));
      cyc(r_rst, r_clr, door_lvl, r_stp, r_sta, r_kv, r_kd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
